aes_iter_enc: RTL and testbench

Parametrised iterative AES encryptor: one round per clock, 128-, 192- or 256-bit key selected at elaboration, with an on-the-fly key schedule and valid/ready handshakes on both sides. It replaces the free-running, divided-clock round sequencing of the current top with a single-clock FSM. It sits between the plaintext source and the ciphertext sink, and SubBytes/SubWord use the team's optimised combinational `aes_sbox`, which is 8-bit in and 8-bit out.

---
 rtl/aes_iter_enc.sv | 265 ++++++++++++++++++++++++++
 tb/tb_aes_iter_enc.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_iter_enc.sv
// Iterative AES encryptor: one round per clock, on-the-fly key schedule, 128/192/256-bit keys.
// Also holds aes_sbox, the combinational byte substitution shared by datapath and key schedule.

module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = x;
    acc = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  logic [7:0] w_inv;

  assign w_inv  = gf_inv(i_byte);
  assign o_byte = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
                ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;

endmodule

module aes_iter_enc #(
  parameter int unsigned KEY_W = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [KEY_W-1:0] key,
  input  logic [127:0]     plaintext,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     ciphertext,
  output logic             busy,
  output logic [3:0]       round_cnt
);

  localparam int NK = int'(KEY_W / 32);
  localparam int NR = NK + 6;

  if (KEY_W != 128 && KEY_W != 192 && KEY_W != 256) begin : g_bad_key_w
    $error("aes_iter_enc: KEY_W must be 128, 192 or 256");
  end

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  state_e       r_state;
  logic [127:0] r_blk;
  logic [31:0]  r_win [NK];
  logic [3:0]   r_mod;
  logic [7:0]   r_rcon;
  logic [3:0]   r_round;
  logic [127:0] r_ct;
  logic         r_in_ready;
  logic         r_out_valid;
  logic         r_busy;

  logic [3:0]   w_spec;
  logic [3:0]   w_rot;
  logic [1:0]   w_ksel;
  logic [31:0]  w_idp [4];
  logic [31:0]  w_sw_in;
  logic [31:0]  w_sw_out;
  logic [31:0]  w_ext [NK+4];
  logic [31:0]  w_win_nxt [NK];
  logic [3:0]   w_mod_nxt;
  logic [7:0]   w_rcon_nxt;
  logic [127:0] w_rk;
  logic         w_first;
  logic         w_last;
  logic [127:0] w_sb;
  logic [127:0] w_sr;
  logic [127:0] w_blk_nxt;

  assign w_first = (r_round == 4'd1);
  assign w_last  = (r_round == 4'(NR));

  // Locate the single word of this group that needs SubWord; its input comes from an
  // identity-only copy of the chain so the shared S-boxes never feed back into themselves.
  always_comb begin
    int m;
    w_ksel = '0;
    w_spec = '0;
    w_rot  = '0;
    for (int k = 3; k >= 0; k--) begin
      m = int'(r_mod) + k;
      if (m >= NK) m = m - NK;
      w_rot[k]  = (m == 0);
      w_spec[k] = (m == 0) || (NK == 8 && m == 4);
      if (w_spec[k]) w_ksel = 2'(k);
    end
    w_idp[0] = r_win[NK-1];
    for (int k = 1; k < 4; k++) begin
      w_idp[k] = r_win[k-1] ^ w_idp[k-1];
    end
    w_sw_in = w_rot[w_ksel] ? {w_idp[w_ksel][23:0], w_idp[w_ksel][31:24]} : w_idp[w_ksel];
  end

  for (genvar b = 0; b < 4; b++) begin : g_subword
    aes_sbox u_sbox (
      .i_byte(w_sw_in[31-8*b -: 8]),
      .o_byte(w_sw_out[31-8*b -: 8])
    );
  end

  // Round 1 only needs the words missing from the initial key; later rounds need 4 new words.
  always_comb begin
    logic [31:0] g;
    int n;
    int m;
    for (int j = 0; j < NK; j++) begin
      w_ext[j] = r_win[j];
    end
    for (int k = 0; k < 4; k++) begin
      if (w_spec[k] && w_ksel == 2'(k)) begin
        g = w_sw_out ^ (w_rot[k] ? {r_rcon, 24'h0} : 32'h0);
      end else begin
        g = w_ext[NK+k-1];
      end
      w_ext[NK+k] = w_ext[k] ^ g;
    end
    n = w_first ? 8 - NK : 4;
    w_rcon_nxt = r_rcon;
    for (int k = 0; k < 4; k++) begin
      if (k < n && w_rot[k]) w_rcon_nxt = xtime(r_rcon);
    end
    m = int'(r_mod) + n;
    if (m >= NK) m = m - NK;
    w_mod_nxt = 4'(m);
    for (int j = 0; j < NK; j++) begin
      w_win_nxt[j] = w_first ? w_ext[j+8-NK] : w_ext[j+4];
    end
    w_rk = w_first ? {w_ext[4], w_ext[5], w_ext[6], w_ext[7]}
                   : {w_ext[NK], w_ext[NK+1], w_ext[NK+2], w_ext[NK+3]};
  end

  for (genvar b = 0; b < 16; b++) begin : g_subbytes
    aes_sbox u_sbox (
      .i_byte(r_blk[127-8*b -: 8]),
      .o_byte(w_sb[127-8*b -: 8])
    );
  end

  // Byte b sits at row b%4, column b/4; ShiftRows pulls row r from column c+r.
  always_comb begin
    int src;
    logic [31:0] col;
    w_sr      = '0;
    w_blk_nxt = '0;
    for (int b = 0; b < 16; b++) begin
      src = 4 * (((b / 4) + (b % 4)) % 4) + (b % 4);
      w_sr[127-8*b -: 8] = w_sb[127-8*src -: 8];
    end
    for (int c = 0; c < 4; c++) begin
      col = w_last ? w_sr[127-32*c -: 32] : mix_col(w_sr[127-32*c -: 32]);
      w_blk_nxt[127-32*c -: 32] = col ^ w_rk[127-32*c -: 32];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_blk       <= '0;
      r_mod       <= '0;
      r_rcon      <= '0;
      r_round     <= '0;
      r_ct        <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      for (int j = 0; j < NK; j++) begin
        r_win[j] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_blk      <= plaintext ^ key[KEY_W-1 -: 128];
            for (int j = 0; j < NK; j++) begin
              r_win[j] <= key[KEY_W-1-32*j -: 32];
            end
            r_mod      <= '0;
            r_rcon     <= 8'h01;
            r_round    <= 4'd1;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= ROUND;
          end
        end
        ROUND: begin
          r_blk  <= w_blk_nxt;
          r_mod  <= w_mod_nxt;
          r_rcon <= w_rcon_nxt;
          for (int j = 0; j < NK; j++) begin
            r_win[j] <= w_win_nxt[j];
          end
          if (w_last) begin
            r_ct        <= w_blk_nxt;
            r_round     <= '0;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_round <= r_round + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign busy       = r_busy;
  assign ciphertext = r_ct;
  assign round_cnt  = r_round;

endmodule

// File: tb/tb_aes_iter_enc.sv
// Bench for aes_iter_enc: three instances (128/192/256-bit keys) against a FIPS-197 style model.

module tb_aes_iter_enc;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [255:0] k_all = '0;
  logic [127:0] pt = '0;
  logic [2:0]   ir;
  logic [2:0]   ov;
  logic [2:0]   bz;
  logic [127:0] ct [3];
  logic [3:0]   rc [3];

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] sbox_t [256];

  typedef struct {
    logic [255:0] k;
    logic [127:0] p;
    logic [127:0] e128;
    logic [127:0] e192;
    logic [127:0] e256;
  } vec_t;

  localparam int NV = 10;
  vec_t v [NV];

  always #5 clk = ~clk;

  aes_iter_enc #(.KEY_W(128)) u_dut128 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .key(k_all[255:128]),
    .plaintext(pt), .out_valid(ov[0]), .out_ready(out_ready), .ciphertext(ct[0]),
    .busy(bz[0]), .round_cnt(rc[0])
  );
  aes_iter_enc #(.KEY_W(192)) u_dut192 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .key(k_all[255:64]),
    .plaintext(pt), .out_valid(ov[1]), .out_ready(out_ready), .ciphertext(ct[1]),
    .busy(bz[1]), .round_cnt(rc[1])
  );
  aes_iter_enc #(.KEY_W(256)) u_dut256 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .key(k_all),
    .plaintext(pt), .out_valid(ov[2]), .out_ready(out_ready), .ciphertext(ct[2]),
    .busy(bz[2]), .round_cnt(rc[2])
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    int p;
    int x;
    p = 0;
    x = int'(a);
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x << 1;
      if ((x & 256) != 0) x = x ^ 'h11b;
    end
    return 8'(p);
  endfunction

  // Table from the definition: brute-force inverse, then the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      for (int i = 0; i < 8; i++) begin
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      end
      sbox_t[x] = s;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sbox_t[x[31:24]], sbox_t[x[23:16]], sbox_t[x[15:8]], sbox_t[x[7:0]]};
  endfunction

  function automatic logic [127:0] aes_model(input logic [255:0] key, input int nk,
                                             input logic [127:0] p);
    logic [31:0]  w [60];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rcon;
    logic [127:0] res;
    int nr;
    nr = nk + 6;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        rcon = 8'h01;
        for (int j = 1; j < i / nk; j++) rcon = gm(rcon, 8'h02);
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rcon, 24'h0};
      end else if (nk > 6 && i % nk == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int b = 0; b < 16; b++) s[b] = p[127-8*b -: 8] ^ w[b/4][31-8*(b%4) -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int b = 0; b < 16; b++) t[b] = sbox_t[s[4*(((b/4)+(b%4))%4)+(b%4)]];
      for (int c = 0; c < 4; c++) begin
        for (int row = 0; row < 4; row++) begin
          if (r < nr) begin
            s[4*c+row] = gm(t[4*c+row], 8'h02) ^ gm(t[4*c+(row+1)%4], 8'h03)
                       ^ t[4*c+(row+2)%4] ^ t[4*c+(row+3)%4];
          end else begin
            s[4*c+row] = t[4*c+row];
          end
        end
      end
      for (int b = 0; b < 16; b++) s[b] = s[b] ^ w[4*r+b/4][31-8*(b%4) -: 8];
    end
    for (int b = 0; b < 16; b++) res[127-8*b -: 8] = s[b];
    return res;
  endfunction

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ir == 3'b111) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_wait", 256'(ok), 256'(1'b1));
  endtask

  // One accept on all three instances, then latency and ciphertext per key size.
  task automatic encrypt_all(input vec_t x, input bit check_rc);
    int lat [3];
    logic [127:0] got [3];
    logic [127:0] exp [3];
    int nov;
    exp[0] = x.e128;
    exp[1] = x.e192;
    exp[2] = x.e256;
    wait_idle();
    k_all = x.k;
    pt = x.p;
    out_ready = 1'b1;
    in_valid = 1'b1;
    nov = 0;
    for (int i = 0; i < 3; i++) begin
      lat[i] = -1;
      got[i] = '0;
    end
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      if (c == 0) in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (ov[i] && lat[i] < 0) begin
          lat[i] = c;
          got[i] = ct[i];
        end
      end
      if (ov[0]) nov++;
      if (check_rc && c <= 10) check("round_cnt", 256'(rc[0]), 256'((c < 10) ? c + 1 : 0));
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("latency_k%0d", 128 + 64 * i), 256'(lat[i]), 256'(10 + 2 * i));
      check($sformatf("cipher_k%0d", 128 + 64 * i), 256'(got[i]), 256'(exp[i]));
    end
    check("out_valid_one_cycle", 256'(nov), 256'(1));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] got1;
    logic [127:0] got2;
    int nov;
    int lat;

    build_sbox();

    v[0].k    = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    v[0].p    = 128'h00112233445566778899aabbccddeeff;
    v[0].e128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    v[0].e192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    v[0].e256 = 128'h8ea2b7ca516745bfeafc49904b496089;
    v[1].k    = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0};
    v[1].p    = 128'h3243f6a8885a308d313198a2e0370734;
    v[1].e128 = 128'h3925841d02dc09fbdc118597196a0b32;
    for (int i = 1; i < NV; i++) begin
      if (i >= 2) begin
        v[i].k = {$urandom(), $urandom(), $urandom(), $urandom(),
                  $urandom(), $urandom(), $urandom(), $urandom()};
        v[i].p = {$urandom(), $urandom(), $urandom(), $urandom()};
        v[i].e128 = aes_model(v[i].k, 4, v[i].p);
      end
      v[i].e192 = aes_model({v[i].k[255:64], 64'h0}, 6, v[i].p);
      v[i].e256 = aes_model(v[i].k, 8, v[i].p);
    end

    repeat (3) @(negedge clk);
    check("rst_in_ready", 256'(ir[0]), 256'(1'b1));
    check("rst_out_valid", 256'(ov[0]), 256'(1'b0));
    check("rst_busy", 256'(bz[0]), 256'(1'b0));
    check("rst_round_cnt", 256'(rc[0]), 256'(0));
    check("rst_ciphertext", 256'(ct[0]), 256'(0));
    rst = 1'b0;

    for (int i = 0; i < NV; i++) encrypt_all(v[i], i == 1);

    // Back-to-back with in_valid held high
    wait_idle();
    k_all = v[2].k;
    pt = v[2].p;
    in_valid = 1'b1;
    nov = 0;
    got1 = '0;
    got2 = '0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (ov[0]) begin
        nov++;
        if (c == 10) got1 = ct[0];
        if (c == 22) got2 = ct[0];
      end
      if (c == 10 || c == 22) check("b2b_out_valid", 256'(ov[0]), 256'(1'b1));
      if (c == 10) begin
        k_all = v[3].k;
        pt = v[3].p;
      end
      if (c == 11) check("b2b_in_ready", 256'(ir[0]), 256'(1'b1));
      if (c == 12) in_valid = 1'b0;
    end
    check("b2b_count", 256'(nov), 256'(2));
    check("b2b_first", 256'(got1), 256'(v[2].e128));
    check("b2b_second", 256'(got2), 256'(v[3].e128));

    // Sink stall for 20 cycles
    wait_idle();
    k_all = v[4].k;
    pt = v[4].p;
    in_valid = 1'b1;
    out_ready = 1'b0;
    for (int c = 0; c < 31; c++) begin
      @(negedge clk);
      if (c == 0) in_valid = 1'b0;
      if (c >= 10 && c < 30) begin
        check("stall_hold", 256'({ov[0], ir[0], ct[0]}), 256'({1'b1, 1'b0, v[4].e128}));
      end
      if (c == 29) out_ready = 1'b1;
      if (c == 30) check("stall_release", 256'({ir[0], ov[0]}), 256'({1'b1, 1'b0}));
    end

    // Input interference while busy
    wait_idle();
    k_all = v[5].k;
    pt = v[5].p;
    in_valid = 1'b1;
    nov = 0;
    lat = -1;
    got1 = '0;
    for (int c = 0; c < 26; c++) begin
      @(negedge clk);
      if (c == 0) in_valid = 1'b0;
      if (c >= 1 && c <= 7) begin
        k_all = {$urandom(), $urandom(), $urandom(), $urandom(),
                 $urandom(), $urandom(), $urandom(), $urandom()};
        pt = {$urandom(), $urandom(), $urandom(), $urandom()};
        in_valid = (c <= 5) && (c % 2 == 1);
      end
      if (ov[0]) begin
        nov++;
        if (lat < 0) begin
          lat = c;
          got1 = ct[0];
        end
      end
    end
    check("intf_latency", 256'(lat), 256'(10));
    check("intf_cipher", 256'(got1), 256'(v[5].e128));
    check("intf_no_extra", 256'(nov), 256'(1));
    check("intf_idle", 256'({ir[0], bz[0], rc[0]}), 256'({1'b1, 1'b0, 4'd0}));

    // Reset at round 5
    wait_idle();
    k_all = v[6].k;
    pt = v[6].p;
    in_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) in_valid = 1'b0;
      if (c == 4) begin
        check("abort_round", 256'(rc[0]), 256'(5));
        rst = 1'b1;
      end
      if (c == 5) begin
        rst = 1'b0;
        check("abort_out_valid", 256'(ov[0]), 256'(1'b0));
        check("abort_busy", 256'(bz[0]), 256'(1'b0));
        check("abort_in_ready", 256'(ir[0]), 256'(1'b1));
        check("abort_ciphertext", 256'(ct[0]), 256'(0));
        check("abort_round_cnt", 256'(rc[0]), 256'(0));
      end
    end
    encrypt_all(v[7], 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
